// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60Hz raster timing generator running on the 25 MHz pixel clock.
//   Produces the hc/vc scan counters with aligned valid/line_start/frame_tick
//   strobes, a frame counter, and hsync/vsync delayed by PIPE_DLY cycles so
//   they line up with the downstream pixel-colour pipeline.
//
// Ports
//   clk_25m     in   1   pixel clock
//   rst         in   1   synchronous, active-high reset
//   hc          out  10  horizontal counter, 0..H_TOTAL-1
//   vc          out  10  vertical counter, 0..V_TOTAL-1
//   valid       out  1   hc/vc inside the visible area
//   hsync_o     out  1   horizontal sync, delayed PIPE_DLY cycles
//   vsync_o     out  1   vertical sync, delayed PIPE_DLY cycles
//   line_start  out  1   pulse while hc==0
//   frame_tick  out  1   pulse at hc==0, vc==V_VIS (start of vblank)
//   frame_cnt   out  16  frames completed, steps with frame_tick
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk_25m,
  input  logic        rst,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        valid,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        line_start,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Range bounds are 11 bits so an end equal to 1024 does not wrap to 0.
  localparam logic [10:0] H_VIS_B  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_B  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic        ACT      = SYNC_POL;
  localparam logic        INACT    = ~SYNC_POL;

  // Cleared by reset; the first cycle after release holds the counters at
  // 0/0 so that position is presented with valid/line_start asserted.
  logic                run;
  logic [9:0]          hc_next;
  logic [9:0]          vc_next;
  logic                valid_next;
  logic                tick_next;
  logic                hs_raw;
  logic                vs_raw;
  logic [PIPE_DLY:0]   hs_pipe;  // [0] is aligned with hc/vc
  logic [PIPE_DLY:0]   vs_pipe;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hc_next = '0;
    vc_next = '0;
    if (run) begin
      if (hc == H_LAST) begin
        hc_next = '0;
        vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc_next = hc + 10'd1;
        vc_next = vc;
      end
    end
  end

  // Strobes and raw syncs are decoded from next-state counters so that,
  // once registered, they describe the hc/vc value shown in the same cycle.
  always_comb begin
    valid_next = ({1'b0, hc_next} < H_VIS_B) && ({1'b0, vc_next} < V_VIS_B);
    tick_next  = (hc_next == 10'd0) && ({1'b0, vc_next} == V_VIS_B);
    hs_raw     = ({1'b0, hc_next} >= HS_START) && ({1'b0, hc_next} < HS_END);
    vs_raw     = ({1'b0, vc_next} >= VS_START) && ({1'b0, vc_next} < VS_END);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      run        <= 1'b0;
      hc         <= '0;
      vc         <= '0;
      valid      <= 1'b0;
      line_start <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      // Flushing the delay lines drops any sync pulse already in flight.
      hs_pipe    <= {(PIPE_DLY + 1){INACT}};
      vs_pipe    <= {(PIPE_DLY + 1){INACT}};
    end else begin
      run        <= 1'b1;
      hc         <= hc_next;
      vc         <= vc_next;
      valid      <= valid_next;
      line_start <= (hc_next == 10'd0);
      frame_tick <= tick_next;
      frame_cnt  <= frame_cnt + {15'd0, tick_next};
      hs_pipe[0] <= hs_raw ? ACT : INACT;
      vs_pipe[0] <= vs_raw ? ACT : INACT;
      for (int i = 1; i <= PIPE_DLY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hsync_o = hs_pipe[PIPE_DLY];
  assign vsync_o = vs_pipe[PIPE_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock and reset: dut_a with PIPE_DLY=0 and dut_b with
//   PIPE_DLY=2. A raster-position model (linear pixel index modulo the frame
//   size, with sync history arrays) is compared against both every cycle;
//   literal checks at hand-picked raster positions pin the model. Long
//   vertical distances are skipped by forcing vc (and frame_cnt) across one
//   clock edge, with the same jump applied to the model.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HT = 800;
  localparam int VT = 525;
  localparam int HV = 640;
  localparam int VV = 480;
  localparam int HS0 = 656, HS1 = 752;
  localparam int VS0 = 490, VS1 = 492;
  localparam int PD [2] = '{0, 2};

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;

  logic [9:0]  hc_a, vc_a, hc_b, vc_b;
  logic        valid_a, hs_a, vs_a, ls_a, ft_a;
  logic        valid_b, hs_b, vs_b, ls_b, ft_b;
  logic [15:0] fc_a, fc_b;

  vga_timing_gen #(.PIPE_DLY(0)) dut_a (
    .clk_25m(clk_25m), .rst(rst), .hc(hc_a), .vc(vc_a), .valid(valid_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .line_start(ls_a), .frame_tick(ft_a),
    .frame_cnt(fc_a)
  );

  vga_timing_gen #(.PIPE_DLY(2)) dut_b (
    .clk_25m(clk_25m), .rst(rst), .hc(hc_b), .vc(vc_b), .valid(valid_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .line_start(ls_b), .frame_tick(ft_b),
    .frame_cnt(fc_b)
  );

  always #20 clk_25m = ~clk_25m;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mh [2];
  int          mv [2];
  bit          mhold [2];
  bit          mval [2], mls [2], mft [2];
  logic [15:0] mfc [2];
  bit          hact [2][8];   // [k] = raw hsync active k cycles ago
  bit          vact [2][8];
  bit          model_ok = 1'b0;

  // Jump requests from the stimulus, applied at the next edge.
  int          ovr_seq = 0, ovr_seen = 0;
  logic [9:0]  frc_vc;
  bit          frc_fc_en;
  logic [15:0] frc_fc;

  always @(posedge clk_25m) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mh[i] = 0; mv[i] = 0; mhold[i] = 1'b1;
        mval[i] = 1'b0; mls[i] = 1'b0; mft[i] = 1'b0; mfc[i] = 16'd0;
        for (int k = 0; k < 8; k++) begin
          hact[i][k] = 1'b0;
          vact[i][k] = 1'b0;
        end
      end else begin
        if (ovr_seq != ovr_seen) begin
          mv[i] = int'(frc_vc);
          if (frc_fc_en) mfc[i] = frc_fc;
        end
        if (mhold[i]) begin
          mh[i] = 0; mv[i] = 0; mhold[i] = 1'b0;
        end else begin
          int idx;
          idx   = (mv[i] * HT + mh[i] + 1) % (HT * VT);
          mh[i] = idx % HT;
          mv[i] = idx / HT;
        end
        mval[i] = (mh[i] < HV) && (mv[i] < VV);
        mls[i]  = (mh[i] == 0);
        mft[i]  = (mh[i] == 0) && (mv[i] == VV);
        if (mft[i]) mfc[i] = mfc[i] + 16'd1;
        for (int k = 7; k > 0; k--) begin
          hact[i][k] = hact[i][k-1];
          vact[i][k] = vact[i][k-1];
        end
        hact[i][0] = (mh[i] >= HS0) && (mh[i] < HS1);
        vact[i][0] = (mv[i] >= VS0) && (mv[i] < VS1);
      end
    end
    if (ovr_seq != ovr_seen) ovr_seen = ovr_seq;
    if (rst) model_ok = 1'b1;
  end

  function automatic logic [40:0] model_vec(input int i);
    logic hs, vs;
    hs = hact[i][PD[i]] ? 1'b0 : 1'b1;   // active-low syncs
    vs = vact[i][PD[i]] ? 1'b0 : 1'b1;
    return {10'(mh[i]), 10'(mv[i]), mval[i], hs, vs, mls[i], mft[i], mfc[i]};
  endfunction

  always @(negedge clk_25m) begin
    if (model_ok) begin
      check("model_a", {hc_a, vc_a, valid_a, hs_a, vs_a, ls_a, ft_a, fc_a}, model_vec(0));
      check("model_b", {hc_b, vc_b, valid_b, hs_b, vs_b, ls_b, ft_b, fc_b}, model_vec(1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int h, input int v, input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_25m);
      if (int'(hc_a) == h && int'(vc_a) == v) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check($sformatf("reach_%0d_%0d", h, v), 64'd0, 64'd1);
  endtask

  // Called at a negedge; holds the force across one rising edge.
  task automatic jump(input logic [9:0] v, input bit fc_en, input logic [15:0] f);
    #3;
    frc_vc = v; frc_fc_en = fc_en; frc_fc = f;
    force dut_a.vc = frc_vc;
    force dut_b.vc = frc_vc;
    if (fc_en) begin
      force dut_a.frame_cnt = frc_fc;
      force dut_b.frame_cnt = frc_fc;
    end
    ovr_seq++;
    @(posedge clk_25m);
    #3;
    release dut_a.vc;
    release dut_b.vc;
    if (fc_en) begin
      release dut_a.frame_cnt;
      release dut_b.frame_cnt;
    end
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clk_25m);
    check("rst_hc", hc_a, 0);
    check("rst_vc", vc_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_fc", fc_a, 0);
    check("rst_syncs", {hs_a, vs_a, hs_b, vs_b}, 4'b1111);
    #3 rst = 1'b0;
    @(negedge clk_25m);
    check("rel_pos", {hc_a, vc_a}, 20'd0);
    check("rel_valid_ls", {valid_a, ls_a}, 2'b11);

    // Line 0 horizontal edges
    wait_pos(639, 0, 1000);  check("valid_639", valid_a, 1);
    wait_pos(640, 0, 10);    check("valid_640", valid_a, 0);
    wait_pos(655, 0, 100);   check("hs_a_655", hs_a, 1);
    wait_pos(656, 0, 10);    check("hs_a_656", hs_a, 0);
    wait_pos(657, 0, 10);    check("hs_b_657", hs_b, 1);
    wait_pos(658, 0, 10);    check("hs_b_658", hs_b, 0);
    wait_pos(751, 0, 100);   check("hs_a_751", hs_a, 0);
    wait_pos(752, 0, 10);    check("hs_a_752", hs_a, 1);
    wait_pos(753, 0, 10);    check("hs_b_753", hs_b, 0);
    wait_pos(754, 0, 10);    check("hs_b_754", hs_b, 1);

    // Line wrap
    wait_pos(799, 0, 100);
    @(negedge clk_25m);
    check("wrap_line", {hc_a, vc_a, ls_a}, {10'd0, 10'd1, 1'b1});

    // Vblank entry and vsync window
    jump(10'd479, 1'b0, 16'd0);
    wait_pos(0, 480, 2000);
    check("tick_480", {ft_a, fc_a, valid_a}, {1'b1, 16'd1, 1'b0});
    @(negedge clk_25m);
    check("tick_once", ft_a, 0);
    wait_pos(0, 489, 12000); check("vs_489", vs_a, 1);
    wait_pos(0, 490, 1000);  check("vs_490", vs_a, 0);
    wait_pos(799, 491, 2000); check("vs_491_end", vs_a, 0);
    @(negedge clk_25m);      check("vs_492", vs_a, 1);

    // Frame wrap
    jump(10'd523, 1'b0, 16'd0);
    wait_pos(799, 524, 2000);
    @(negedge clk_25m);
    check("wrap_frame", {hc_a, vc_a}, 20'd0);

    // frame_cnt rollover
    jump(10'd479, 1'b1, 16'hFFFF);
    wait_pos(0, 480, 2000);
    check("fc_wrap", {ft_a, fc_a}, {1'b1, 16'd0});

    // Reset during an hsync pulse
    jump(10'd300, 1'b0, 16'd0);
    wait_pos(700, 300, 2000);
    check("hs_active_700", {hs_a, hs_b}, 2'b00);
    #3 rst = 1'b1;
    @(negedge clk_25m);
    check("midrst_pos", {hc_a, vc_a, hc_b, vc_b}, 40'd0);
    check("midrst_syncs", {hs_a, hs_b, vs_a, vs_b, valid_a, fc_a}, {5'b11110, 16'd0});
    #3 rst = 1'b0;

    // Randomised reset pulses, model-checked every cycle
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(50, 2500)) @(negedge clk_25m);
      #3 rst = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk_25m);
      #3 rst = 1'b0;
    end
    repeat (900) @(negedge clk_25m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
